// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
//   - ALUCtrl codes of the four operations that start the sequencer
//   - sequencer state encoding and iteration count
package muldiv_seq_pkg;

  // ALUCtrl codes (5-bit) that start an operation.
  localparam logic [4:0] AluMult  = 5'b11000;
  localparam logic [4:0] AluMultu = 5'b11001;
  localparam logic [4:0] AluDiv   = 5'b11010;
  localparam logic [4:0] AluDivu  = 5'b11011;

  // Iterations per operation; equals the operand width.
  localparam int unsigned Iter = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFin  = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_seq_iter.sv
// One combinational iteration of the multiply/divide datapath.
// Ports:
//   is_div  - 1: restoring divide step, 0: shift-add multiply step
//   acc     - 64-bit accumulator; multiply: {partial, multiplier},
//             divide: {remainder, dividend/quotient}
//   opnd    - multiplicand (multiply) or divisor (divide)
//   acc_nxt - accumulator after this iteration
module muldiv_seq_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opnd,
  output logic [2*XLEN-1:0] acc_nxt
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   tmp;
  logic [XLEN-1:0] diff;
  logic            ge;

  always_comb begin
    // Multiply: add multiplicand to the upper half when the multiplier LSB is set, keep the
    // carry and shift the whole accumulator right.
    sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    // Divide: shift the next dividend bit into the remainder and try a subtraction.
    tmp  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    ge   = (tmp >= {1'b0, opnd});
    // The true difference is below the divisor, so the low bits are exact.
    diff = tmp[XLEN-1:0] - opnd;
    if (is_div) begin
      acc_nxt = {(ge ? diff : tmp[XLEN-1:0]), acc[XLEN-2:0], ge};
    end else begin
      acc_nxt = {sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer with architectural HI/LO registers.
// Executes MULT/MULTU/DIV/DIVU in ITER+2 cycles, stalls dependent EX-stage instructions while
// busy and cancels a pending operation on flush.
// Ports:
//   clk, rst           - clock, asynchronous active-low reset
//   start_i, aluctrl_i - start request and operation code
//   src0_i, src1_i     - rs (multiplicand/dividend), rt (multiplier/divisor)
//   flush_i            - cancel pending operation, suppress all updates this cycle
//   mthi_i, mtlo_i     - write mt_data_i to HI/LO (idle only)
//   mf_req_i           - EX-stage instruction reads HI/LO
//   busy_o, stall_o    - operation in progress, pipeline freeze
//   done_o             - one-cycle pulse after HI/LO were written by an operation
//   hi_o, lo_o         - HI/LO registers
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = Iter
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [4:0]      aluctrl_i,
  input  logic [XLEN-1:0] src0_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic            flush_i,
  input  logic            mthi_i,
  input  logic            mtlo_i,
  input  logic [XLEN-1:0] mt_data_i,
  input  logic            mf_req_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  md_state_e         state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d, acc_step;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic              div_q, div_d, dz_q, dz_d, negq_q, negq_d, negr_q, negr_d;
  logic              done_q, done_d;

  logic              valid_op, is_div_op, is_sgn_op;
  logic [XLEN-1:0]   s0_abs, s1_abs, quo_fix, rem_fix;
  logic [2*XLEN-1:0] prod_fix;

  muldiv_seq_iter #(
    .XLEN(XLEN)
  ) u_iter (
    .is_div (div_q),
    .acc    (acc_q),
    .opnd   (opnd_q),
    .acc_nxt(acc_step)
  );

  always_comb begin
    valid_op  = start_i && (aluctrl_i inside {AluMult, AluMultu, AluDiv, AluDivu});
    is_div_op = (aluctrl_i == AluDiv) || (aluctrl_i == AluDivu);
    is_sgn_op = (aluctrl_i == AluMult) || (aluctrl_i == AluDiv);
    s0_abs    = (is_sgn_op && src0_i[XLEN-1]) ? -src0_i : src0_i;
    s1_abs    = (is_sgn_op && src1_i[XLEN-1]) ? -src1_i : src1_i;
    prod_fix  = negq_q ? -acc_q : acc_q;
    quo_fix   = negq_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix   = negr_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div_d   = div_q;
    dz_d    = dz_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    done_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (valid_op) begin
          div_d  = is_div_op;
          negq_d = is_sgn_op && (src0_i[XLEN-1] ^ src1_i[XLEN-1]);
          negr_d = is_sgn_op && src0_i[XLEN-1];
          cnt_d  = '0;
          dz_d   = is_div_op && (src1_i == '0);
          if (is_div_op && (src1_i == '0)) begin
            // Keep the raw dividend; it becomes HI unchanged.
            acc_d   = {{XLEN{1'b0}}, src0_i};
            state_d = StFin;
          end else begin
            acc_d   = {{XLEN{1'b0}}, (is_div_op ? s0_abs : s1_abs)};
            opnd_d  = is_div_op ? s1_abs : s0_abs;
            state_d = StRun;
          end
        end else begin
          if (mthi_i) hi_d = mt_data_i;
          if (mtlo_i) lo_d = mt_data_i;
        end
      end
      StRun: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(ITER - 1)) state_d = StFin;
      end
      StFin: begin
        if (dz_q) begin
          hi_d = acc_q[XLEN-1:0];
          lo_d = '1;
        end else if (div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*XLEN-1:XLEN];
          lo_d = prod_fix[XLEN-1:0];
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Flush overrides start, MT writes and completion.
    if (flush_i) begin
      state_d = StIdle;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      dz_q    <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div_q   <= div_d;
      dz_q    <= dz_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      done_q  <= done_d;
    end
  end

  assign busy_o  = (state_q != StIdle);
  assign stall_o = busy_o && (start_i || mf_req_i || mthi_i || mtlo_i);
  assign done_o  = done_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: arithmetic/latency model compared every cycle, plus
// directed vectors with hand-computed HI/LO values.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i = 1'b0;
  logic [4:0]  aluctrl_i = '0;
  logic [31:0] src0_i = '0, src1_i = '0, mt_data_i = '0;
  logic        flush_i = 1'b0, mthi_i = 1'b0, mtlo_i = 1'b0, mf_req_i = 1'b0;
  logic        busy_o, stall_o, done_o;
  logic [31:0] hi_o, lo_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_seq u_dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .aluctrl_i(aluctrl_i),
    .src0_i   (src0_i),
    .src1_i   (src1_i),
    .flush_i  (flush_i),
    .mthi_i   (mthi_i),
    .mtlo_i   (mtlo_i),
    .mt_data_i(mt_data_i),
    .mf_req_i (mf_req_i),
    .busy_o   (busy_o),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Architectural result {HI, LO} computed with plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    r  = '0;
    if (op == AluMult) begin
      r = sa * sb;
    end else if (op == AluMultu) begin
      r = ua * ub;
    end else if (b == 32'b0) begin
      r = {a, 32'hFFFF_FFFF};
    end else if (op == AluDiv) begin
      sq = sa / sb;
      sr = sa % sb;
      r  = {sr[31:0], sq[31:0]};
    end else begin
      uq = ua / ub;
      ur = ua % ub;
      r  = {ur[31:0], uq[31:0]};
    end
    return r;
  endfunction

  // Cycle model: an accepted op stays pending for 33 edges (1 for divide by zero).
  logic        m_busy, m_done;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  int          m_rem;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_res  <= '0;
      m_rem  <= 0;
    end else begin
      m_done <= 1'b0;
      if (flush_i) begin
        m_busy <= 1'b0;
      end else if (m_busy) begin
        if (m_rem == 1) begin
          m_busy <= 1'b0;
          m_hi   <= m_res[63:32];
          m_lo   <= m_res[31:0];
          m_done <= 1'b1;
        end
        m_rem <= m_rem - 1;
      end else if (start_i && (aluctrl_i inside {AluMult, AluMultu, AluDiv, AluDivu})) begin
        m_busy <= 1'b1;
        m_res  <= model(aluctrl_i, src0_i, src1_i);
        m_rem  <= ((aluctrl_i == AluDiv || aluctrl_i == AluDivu) && src1_i == 0) ? 1 : 33;
      end else begin
        if (mthi_i) m_hi <= mt_data_i;
        if (mtlo_i) m_lo <= mt_data_i;
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_busy", {31'b0, busy_o}, {31'b0, m_busy});
    chk("cmp_done", {31'b0, done_o}, {31'b0, m_done});
    chk("cmp_stall", {31'b0, stall_o},
        {31'b0, m_busy & (start_i | mf_req_i | mthi_i | mtlo_i)});
    chk("cmp_hi", hi_o, m_hi);
    chk("cmp_lo", lo_o, m_lo);
  end

  // Inputs change 1 time unit after the falling edge, after the compare has sampled.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int lat, input int ebusy, input logic mf);
    int n, nbusy, nbad;
    tick();
    start_i = 1'b1; aluctrl_i = op; src0_i = a; src1_i = b; mf_req_i = mf;
    n = 0; nbusy = 0; nbad = 0;
    do begin
      tick();
      start_i = 1'b0;
      n++;
      if (busy_o) nbusy++;
      if (mf && (stall_o !== (done_o ? 1'b0 : 1'b1))) nbad++;
    end while (!done_o && n < 60);
    mf_req_i = 1'b0;
    chk({name, "_latency"}, 32'(n), 32'(lat));
    chk({name, "_busy_cycles"}, 32'(nbusy), 32'(ebusy));
    chk({name, "_hi"}, hi_o, ehi);
    chk({name, "_lo"}, lo_o, elo);
    if (mf) chk({name, "_mf_stall"}, 32'(nbad), 32'd0);
  endtask

  initial begin
    int ndone;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("reset_hi", hi_o, 32'h0);
    chk("reset_lo", lo_o, 32'h0);
    chk("reset_busy", {31'b0, busy_o}, 32'h0);
    chk("reset_done", {31'b0, done_o}, 32'h0);
    tick(); tick();
    rst = 1'b1;
    tick();

    run_op("mult_m3x5", AluMult, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 34, 33, 1);
    run_op("divu_100_7", AluDivu, 32'd100, 32'd7, 32'd2, 32'hE, 34, 33, 0);
    run_op("div_m7_2", AluDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 33, 0);
    run_op("multu_max", AluMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 34, 33, 0);
    run_op("div_ovf", AluDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 34, 33, 0);
    run_op("divu_by0", AluDivu, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 2, 1, 0);
    run_op("div_m20_by0", AluDiv, 32'hFFFF_FFEC, 32'd0, 32'hFFFF_FFEC, 32'hFFFF_FFFF, 2, 1, 0);

    // Unknown op code with start_i is ignored.
    tick();
    start_i = 1'b1; aluctrl_i = 5'b00000;
    tick();
    start_i = 1'b0;
    chk("bad_op_busy", {31'b0, busy_o}, 32'h0);

    // MTHI/MTLO preload, then a flushed MULT leaves HI/LO untouched.
    mthi_i = 1'b1; mt_data_i = 32'h1234;
    tick();
    mthi_i = 1'b0; mtlo_i = 1'b1; mt_data_i = 32'h5678;
    chk("mthi_hi", hi_o, 32'h1234);
    tick();
    mtlo_i = 1'b0;
    chk("mtlo_lo", lo_o, 32'h5678);
    start_i = 1'b1; aluctrl_i = AluMult; src0_i = 32'd7; src1_i = 32'd9;
    tick();
    start_i = 1'b0;
    repeat (9) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_busy", {31'b0, busy_o}, 32'h0);
    chk("flush_hi", hi_o, 32'h1234);
    ndone = 0;
    repeat (40) begin
      tick();
      if (done_o) ndone++;
    end
    chk("flush_no_done", 32'(ndone), 32'd0);
    chk("flush_lo", lo_o, 32'h5678);

    // Reset in the middle of a DIV clears HI/LO at once.
    start_i = 1'b1; aluctrl_i = AluDiv; src0_i = 32'd100; src1_i = 32'd3;
    tick();
    start_i = 1'b0;
    repeat (4) tick();
    chk("pre_rst_busy", {31'b0, busy_o}, 32'h1);
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_hi", hi_o, 32'h0);
    chk("rst_mid_lo", lo_o, 32'h0);
    chk("rst_mid_busy", {31'b0, busy_o}, 32'h0);
    tick();
    rst = 1'b1;
    tick();

    run_op("div_after_rst", AluDiv, 32'd100, 32'hFFFF_FFFD, 32'd1, 32'hFFFF_FFDF, 34, 33, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
